ave8_stream_core: RTL



---
 rtl/ave8_pkg.sv | 27 ++
 rtl/ave8_stream_core_if.sv | 23 ++
 rtl/ave8_window_sum.sv | 36 +++
 rtl/ave8_stream_core.sv | 93 +++++++++
 4 files changed

// File: rtl/ave8_pkg.sv
// Shared types for the 8-tap sliding-window averager; AVE8_ROUND_EN selects round-half-up over floor.
// Sum carries one guard bit so the rounding offset can never overflow.
package ave8_pkg;

    localparam int DATA_W   = 8;
    localparam int WIN_LOG2 = 3;
    localparam int SUM_W    = DATA_W + WIN_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ave8_state_t;

    typedef logic signed [0:DATA_W-1] sample_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    function automatic sample_t ave8_avg(input sum_t s);
        sum_t q;
`ifdef AVE8_ROUND_EN
        q = (s + sum_t'(1 << (WIN_LOG2 - 1))) >>> WIN_LOG2;
        if (q > sum_t'((1 << (DATA_W - 1)) - 1)) begin
            q = sum_t'((1 << (DATA_W - 1)) - 1);
        end
`else
        q = s >>> WIN_LOG2;
`endif
        return sample_t'(q);
    endfunction

endpackage

// File: rtl/ave8_stream_core_if.sv
// Sample-in / result-out handshake bundle: FIFO pop side (rd_incadr/in_empty) and sink push side (wr_incadr/out_full).
// master = averaging core, slave = FIFO and capture models.
interface ave8_stream_core_if;
    import ave8_pkg::*;

    sample_t in_data;
    logic    in_empty;
    logic    rd_incadr;
    sample_t out_data;
    logic    wr_incadr;
    logic    out_full;

    modport master (
        input  in_data, in_empty, out_full,
        output rd_incadr, out_data, wr_incadr
    );

    modport slave (
        output in_data, in_empty, out_full,
        input  rd_incadr, out_data, wr_incadr
    );

endinterface

// File: rtl/ave8_window_sum.sv
// Tap shift register with running sum; sum output already includes din when shift_en is high.
// Updates on the shift edge; no backpressure of its own, the caller gates shift_en.
module ave8_window_sum
    import ave8_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    shift_en,
    input  logic    clr,
    input  sample_t din,
    output sum_t    sum
);

    localparam int TAPS = 1 << WIN_LOG2;

    sample_t taps_q [TAPS];
    sum_t    sum_q;

    // Oldest tap leaves as the new sample enters, so the sum never needs a full re-add.
    assign sum = shift_en ? (sum_q + sum_t'(din) - sum_t'(taps_q[TAPS-1])) : sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
            sum_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
            sum_q <= '0;
        end else if (shift_en) begin
            taps_q[0] <= din;
            for (int i = 1; i < TAPS; i++) taps_q[i] <= taps_q[i-1];
            sum_q <= sum;
        end
    end

endmodule

// File: rtl/ave8_stream_core.sv
// Pops signed samples, emits the 8-tap window average one cycle after each pop; AVE8_ROUND_EN enables rounding.
// One result per cycle; a full sink holds the result stable and stops popping until the push completes.
module ave8_stream_core
    import ave8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    ave8_stream_core_if.master  bus,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic                done
);

    ave8_state_t      state_q, state_d;
    logic             wr_q, wr_d;
    sample_t          out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rd;
    logic pop;
    logic push;
    logic clr;
    sum_t win_sum;

    ave8_window_sum u_win (
        .clk      (clk),
        .rst      (rst),
        .shift_en (pop),
        .clr      (clr),
        .din      (bus.in_data),
        .sum      (win_sum)
    );

    // A pop may coincide with a completing push, keeping the output slot busy back to back.
    assign rd   = (state_q == RUN) && !stop && (!wr_q || !bus.out_full);
    assign pop  = rd && !bus.in_empty;
    assign push = wr_q && !bus.out_full;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        wr_d    = wr_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                clr     = 1'b1;
            end
            RUN: if (stop && (!wr_q || push)) begin
                state_d = DONE;
            end
            DONE: if (start) begin
                state_d = RUN;
                clr     = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_d = 1'b0;
        if (pop) begin
            wr_d  = 1'b1;
            out_d = ave8_avg(win_sum);
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rd_incadr = rd;
    assign bus.out_data  = out_q;
    assign bus.wr_incadr = wr_q;
    assign sample_cnt    = cnt_q;
    assign done          = (state_q == DONE);

endmodule
